// File: rtl/imm_ext_pipe_pkg.sv
// imm_pkg: immediate formats, skid-buffer states and the RV32I immediate extender shared by the decode path.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_U  = 3'd3,
        IMM_J  = 3'd4,
        IMM_ZI = 3'd5
    } imm_src_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [31:0] imm;
        logic        err;
    } ext_t;

    // Produces the 32-bit immediate; bit 31 is the sign for every format except ZI,
    // so wider datapaths extend by replicating it (or zero for ZI).
    function automatic ext_t imm_extend(input logic [31:7] instr, input logic [2:0] src);
        ext_t r;
        r.err = 1'b0;
        case (src)
            IMM_I:   r.imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   r.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   r.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   r.imm = {instr[31:12], 12'b0};
            IMM_J:   r.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_ZI:  r.imm = {20'b0, instr[31:20]};
            default: begin
                r.imm = 32'b0;
                r.err = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_ext_pipe_skid_buf.sv
// imm_skid_buf: generic 2-entry skid buffer with registered in_ready and registered output.
module imm_skid_buf
    import imm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e state, state_n;
    logic [W-1:0] main_q, skid_q;
    logic acc, deq;

    assign acc      = in_valid & in_ready;
    assign deq      = out_valid & out_ready;
    assign out_data = main_q;

    always_comb begin
        state_n = (state == EMPTY) ? (acc ? ONE : EMPTY) :
                  (state == ONE)   ? ((acc && !deq) ? FULL : ((!acc && deq) ? EMPTY : ONE)) :
                                     (deq ? ONE : FULL);
    end

    // in_ready/out_valid are flops tracking the next state rather than decodes of it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= state_n != FULL;
            out_valid <= state_n != EMPTY;
            if (acc && (state == EMPTY || deq))
                main_q <= in_data;
            else if (state == FULL && deq)
                main_q <= skid_q;
            if (state == ONE && acc && !deq)
                skid_q <= in_data;
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined RV32I immediate extender (I/S/B/U/J/ZI) at XLEN, behind a 2-entry skid buffer.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int W = XLEN + TAG_W + 1;

    ext_t ext;
    logic [XLEN-1:0] imm;
    logic unused_opcode;

    assign unused_opcode = ^in_instr[6:0];
    assign ext = imm_extend(in_instr[31:7], in_imm_src);

    if (XLEN == 64) begin : g_wide
        assign imm = {{32{ext.imm[31] & (in_imm_src != IMM_ZI)}}, ext.imm};
    end else begin : g_narrow
        assign imm = ext.imm;
    end

    imm_skid_buf #(.W(W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({imm, in_tag, ext.err}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_imm, out_tag, out_err})
    );

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed self-checking bench for imm_ext_pipe at XLEN=32 and XLEN=64.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0] in_instr, out_imm;
    logic [2:0]  in_imm_src;
    logic [4:0]  in_tag, out_tag;
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_err;
    logic [31:0] w_in_instr;
    logic [63:0] w_out_imm;
    logic [2:0]  w_in_imm_src;
    logic [4:0]  w_in_tag, w_out_tag;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_err(out_err)
    );

    imm_ext_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr),
        .in_imm_src(w_in_imm_src), .in_tag(w_in_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_imm(w_out_imm),
        .out_tag(w_out_tag), .out_err(w_out_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_imm_src = 3'd0; in_tag = 5'd9; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_instr = 32'h0; w_in_imm_src = 3'd0; w_in_tag = 5'd0; w_out_ready = 1'b0;
        step(); step();
        total++;
        if ({out_valid, in_ready, out_imm, out_tag, out_err} !== {1'b0, 1'b1, 32'h0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset32: got v=%0b r=%0b imm=%h tag=%0d err=%0b want v=0 r=1 imm=0 tag=0 err=0",
                     out_valid, in_ready, out_imm, out_tag, out_err);
        end
        total++;
        if ({w_out_valid, w_in_ready, w_out_imm, w_out_tag, w_out_err} !== {1'b0, 1'b1, 64'h0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset64: got v=%0b r=%0b imm=%h want v=0 r=1 imm=0", w_out_valid, w_in_ready, w_out_imm);
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_formats();
        logic [31:0] instr [7]  = '{32'hFFF00093, 32'hFFF00093, 32'hFFF00093, 32'hFE000EE3,
                                    32'h0080006F, 32'h00A12423, 32'h12345037};
        logic [2:0]  src   [7]  = '{3'd0, 3'd5, 3'd6, 3'd2, 3'd4, 3'd1, 3'd3};
        logic [31:0] exp   [7]  = '{32'hFFFFFFFF, 32'h00000FFF, 32'h0, 32'hFFFFFFFC,
                                    32'h00000008, 32'h00000008, 32'h12345000};
        logic        eerr  [7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_instr = instr[i]; in_imm_src = src[i]; in_tag = 5'(i + 1);
            step();
            total++;
            if ({out_valid, out_imm, out_err, out_tag} !== {1'b1, exp[i], eerr[i], 5'(i + 1)}) begin
                bad++;
                $display("FAIL fmt%0d: got v=%0b imm=%h err=%0b tag=%0d want v=1 imm=%h err=%0b tag=%0d",
                         i, out_valid, out_imm, out_err, out_tag, exp[i], eerr[i], i + 1);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL drain: got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_imm_src = 3'd0;
        in_tag = 5'd1; in_instr = 32'h00100093;
        step();
        total++;
        if ({out_valid, in_ready, out_tag, out_imm} !== {1'b1, 1'b1, 5'd1, 32'd1}) begin
            bad++;
            $display("FAIL stall_first: got v=%0b r=%0b tag=%0d imm=%h want v=1 r=1 tag=1 imm=1",
                     out_valid, in_ready, out_tag, out_imm);
        end
        in_tag = 5'd2; in_instr = 32'h00200093;
        step();
        total++;
        if ({out_valid, in_ready, out_tag} !== {1'b1, 1'b0, 5'd1}) begin
            bad++;
            $display("FAIL stall_full: got v=%0b r=%0b tag=%0d want v=1 r=0 tag=1", out_valid, in_ready, out_tag);
        end
        in_tag = 5'd3; in_instr = 32'h00300093;
        step(); step();
        total++;
        if ({in_ready, out_tag, out_imm} !== {1'b0, 5'd1, 32'd1}) begin
            bad++;
            $display("FAIL stall_hold: got r=%0b tag=%0d imm=%h want r=0 tag=1 imm=1", in_ready, out_tag, out_imm);
        end
        out_ready = 1'b1;
        step();
        total++;
        if ({out_valid, in_ready, out_tag, out_imm} !== {1'b1, 1'b1, 5'd2, 32'd2}) begin
            bad++;
            $display("FAIL release2: got v=%0b r=%0b tag=%0d imm=%h want v=1 r=1 tag=2 imm=2",
                     out_valid, in_ready, out_tag, out_imm);
        end
        step();
        in_valid = 1'b0;
        total++;
        if ({out_valid, out_tag, out_imm} !== {1'b1, 5'd3, 32'd3}) begin
            bad++;
            $display("FAIL release3: got v=%0b tag=%0d imm=%h want v=1 tag=3 imm=3", out_valid, out_tag, out_imm);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_dup: got v=%0b want v=0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_imm_src = 3'd0;
        in_tag = 5'd10; in_instr = 32'h00A00093;
        step();
        in_tag = 5'd11; in_instr = 32'h00B00093;
        step();
        total++;
        if ({out_valid, in_ready} !== 2'b10) begin
            bad++;
            $display("FAIL flush_pre: got v=%0b r=%0b want v=1 r=0", out_valid, in_ready);
        end
        flush = 1'b1; in_tag = 5'd12; in_instr = 32'h00C00093;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        total++;
        if ({out_valid, in_ready, out_tag, out_imm, out_err} !== {1'b0, 1'b1, 5'd0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL flush: got v=%0b r=%0b tag=%0d imm=%h want v=0 r=1 tag=0 imm=0",
                     out_valid, in_ready, out_tag, out_imm);
        end
        step(); step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_drop: got v=%0b tag=%0d want v=0", out_valid, out_tag);
        end
    endtask

    task automatic test_xlen64();
        logic [31:0] instr [4] = '{32'h800000B7, 32'hFFF00093, 32'hFFF00093, 32'hFE000EE3};
        logic [2:0]  src   [4] = '{3'd3, 3'd5, 3'd0, 3'd2};
        logic [63:0] exp   [4] = '{64'hFFFFFFFF80000000, 64'h0000000000000FFF,
                                   64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC};
        w_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_in_valid = 1'b1; w_in_instr = instr[i]; w_in_imm_src = src[i]; w_in_tag = 5'(20 + i);
            step();
            total++;
            if ({w_out_valid, w_out_imm, w_out_tag, w_out_err} !== {1'b1, exp[i], 5'(20 + i), 1'b0}) begin
                bad++;
                $display("FAIL x64_%0d: got v=%0b imm=%h tag=%0d want v=1 imm=%h tag=%0d",
                         i, w_out_valid, w_out_imm, w_out_tag, exp[i], 20 + i);
            end
        end
        w_out_ready = 1'b0; w_in_imm_src = 3'd3; w_in_instr = 32'h800000B7;
        step();
        total++;
        if (w_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL x64_full: got r=%0b want r=0", w_in_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; w_in_valid = 1'b0;
        total++;
        if ({w_out_valid, w_in_ready, w_out_imm, w_out_tag, w_out_err} !== {1'b0, 1'b1, 64'h0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL x64_rst: got v=%0b r=%0b imm=%h tag=%0d err=%0b want v=0 r=1 imm=0 tag=0 err=0",
                     w_out_valid, w_in_ready, w_out_imm, w_out_tag, w_out_err);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_stall();
        test_flush();
        test_xlen64();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
